// File: rtl/jpeg_dec_bs_preproc.sv
// jpeg_dec_bs_preproc
//   Bitstream pre-processor in front of the JPEG VLD. Entropy-coded bytes
//   arrive from the DMA. The block removes 0xFF00 byte stuffing and detects
//   RSTn and EOI markers. It packs the data MSB-first into PI_W-bit words and
//   holds them in a show-ahead FIFO. Each FIFO entry carries a marker tag.
//
//   Optional feature (macro JPEG_DEC_RST_SEQ_CHK_EN):
//     When the macro is defined, the block checks that RSTn indices come in
//     the order 0..7 and wraps back to 0. A mismatch sets ERR_INFO[2].
//     When it is undefined, there is no index register and ERR_INFO[2] is 0.
//
//   Handshake: a byte is consumed on every cycle with BS_EN=1. The source
//   must stop within one cycle of BS_AFULL rising. A word is popped on every
//   cycle with PI_REQ=1 and PI_EMPTY=0. PI_REQ is ignored while PI_EMPTY=1.
//   PI and the tag outputs show the head entry while PI_EMPTY=0.
//
//   dbg_state exposes the byte-parser state for observation only.
module jpeg_dec_bs_preproc #(
  parameter int PI_W       = 32,
  parameter int FIFO_DEPTH = 8,
  parameter int FIFO_AW    = 3,
  parameter int AFULL_TH   = 2
) (
  input  logic            HCLK,
  input  logic            HRESETn,
  input  logic            INIT,
  input  logic            BS_EN,
  input  logic [7:0]      BS_DAT,
  output logic            BS_AFULL,
  output logic            PI_EMPTY,
  input  logic            PI_REQ,
  output logic [PI_W-1:0] PI,
  output logic            PI_RST_MRK,
  output logic            PI_EOI_MRK,
  output logic [2:0]      ERR_INFO,
  output logic [1:0]      dbg_state
);

  localparam int NB = PI_W / 8;
  localparam int CW = (NB > 1) ? $clog2(NB) : 1;
  localparam logic [CW-1:0]      LAST_BYTE = CW'(NB - 1);
  localparam logic [FIFO_AW:0]   DEPTH_V   = (FIFO_AW + 1)'(FIFO_DEPTH);
  localparam logic [FIFO_AW:0]   AFULL_V   = (FIFO_AW + 1)'(AFULL_TH);

  typedef enum logic [1:0] {
    ST_DATA    = 2'd0,
    ST_FF_SEEN = 2'd1,
    ST_DONE    = 2'd2
  } state_t;

  // Parser, packer and FIFO control state
  state_t             state_q, state_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [PI_W-1:0]    pack_q, pack_d;   // unfilled bytes are kept at 0xFF
  logic [FIFO_AW:0]   wr_ptr_q, wr_ptr_d;
  logic [FIFO_AW:0]   rd_ptr_q, rd_ptr_d;
  logic               afull_q, afull_d;
  logic [2:0]         err_q, err_d;

  // FIFO storage: {eoi_tag, rst_tag, word}
  logic [PI_W+1:0]    fifo_mem [FIFO_DEPTH];

  logic               byte_vld;
  logic               do_append;
  logic [7:0]         app_byte;
  logic [PI_W-1:0]    appended;
  logic               push;
  logic [PI_W+1:0]    push_entry;
  logic               unk_err;
  logic               seq_err;
  logic [FIFO_AW:0]   count;
  logic               fifo_empty;
  logic               fifo_full;
  logic               pop;
  logic               push_ok;
  logic               ovf;
  logic [FIFO_AW:0]   count_d;
  logic [PI_W+1:0]    head;

  // Writes one byte into the packer slot selected by idx (slot 0 = MSB)
  function automatic logic [PI_W-1:0] place_byte(input logic [PI_W-1:0] w,
                                                 input logic [CW-1:0]   idx,
                                                 input logic [7:0]      b);
    logic [PI_W-1:0] r;
    r = w;
    for (int i = 0; i < NB; i++) begin
      if (idx == i[CW-1:0]) r[PI_W-1-8*i -: 8] = b;
    end
    return r;
  endfunction

`ifdef JPEG_DEC_RST_SEQ_CHK_EN
  logic [2:0] rst_idx_q, rst_idx_d;
`endif

  assign byte_vld = BS_EN & ~INIT;
  assign appended = place_byte(pack_q, cnt_q, app_byte);

  // Byte parser: destuffing, marker detection and word packing
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pack_d     = pack_q;
    do_append  = 1'b0;
    app_byte   = BS_DAT;
    push       = 1'b0;
    push_entry = {2'b00, pack_q};
    unk_err    = 1'b0;
    seq_err    = 1'b0;
`ifdef JPEG_DEC_RST_SEQ_CHK_EN
    rst_idx_d  = rst_idx_q;
`endif
    if (byte_vld) begin
      case (state_q)
        ST_DATA: begin
          if (BS_DAT == 8'hFF) state_d = ST_FF_SEEN;
          else                 do_append = 1'b1;
        end
        ST_FF_SEEN: begin
          if (BS_DAT == 8'h00) begin
            do_append = 1'b1;
            app_byte  = 8'hFF;
            state_d   = ST_DATA;
          end else if (BS_DAT == 8'hFF) begin
            state_d = ST_FF_SEEN;
          end else if (BS_DAT[7:3] == 5'b11010) begin
            // RSTn: flush the partial word (or an all-ones word) with the RST tag
            push       = 1'b1;
            push_entry = {2'b01, pack_q};
            pack_d     = '1;
            cnt_d      = '0;
            state_d    = ST_DATA;
`ifdef JPEG_DEC_RST_SEQ_CHK_EN
            seq_err    = (BS_DAT[2:0] != rst_idx_q);
            rst_idx_d  = BS_DAT[2:0] + 3'd1;
`endif
          end else if (BS_DAT == 8'hD9) begin
            push       = 1'b1;
            push_entry = {2'b10, pack_q};
            pack_d     = '1;
            cnt_d      = '0;
            state_d    = ST_DONE;
          end else begin
            unk_err = 1'b1;
            state_d = ST_DATA;
          end
        end
        default: ;
      endcase
    end
    if (do_append) begin
      if (cnt_q == LAST_BYTE) begin
        push       = 1'b1;
        push_entry = {2'b00, appended};
        pack_d     = '1;
        cnt_d      = '0;
      end else begin
        pack_d = appended;
        cnt_d  = cnt_q + 1'b1;
      end
    end
    if (INIT) begin
      state_d = ST_DATA;
      cnt_d   = '0;
      pack_d  = '1;
`ifdef JPEG_DEC_RST_SEQ_CHK_EN
      rst_idx_d = 3'd0;
`endif
    end
  end

  assign count      = wr_ptr_q - rd_ptr_q;
  assign fifo_empty = (count == '0);
  assign fifo_full  = (count == DEPTH_V);
  assign pop        = PI_REQ & ~fifo_empty & ~INIT;
  assign push_ok    = push & (~fifo_full | pop);
  assign ovf        = push & fifo_full & ~pop;

  // FIFO pointers, almost-full flag and sticky error flags
  always_comb begin
    wr_ptr_d = wr_ptr_q + {{FIFO_AW{1'b0}}, push_ok};
    rd_ptr_d = rd_ptr_q + {{FIFO_AW{1'b0}}, pop};
    count_d  = wr_ptr_d - rd_ptr_d;
    afull_d  = ((DEPTH_V - count_d) <= AFULL_V);
    err_d    = err_q | {seq_err, ovf, unk_err};
    if (INIT) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      afull_d  = 1'b0;
      err_d    = '0;
    end
  end

  // State registers with asynchronous reset
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) begin
      state_q  <= ST_DATA;
      cnt_q    <= '0;
      pack_q   <= '1;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      afull_q  <= 1'b0;
      err_q    <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      pack_q   <= pack_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      afull_q  <= afull_d;
      err_q    <= err_d;
    end
  end

`ifdef JPEG_DEC_RST_SEQ_CHK_EN
  // Expected RST index register
  always_ff @(posedge HCLK or negedge HRESETn) begin
    if (!HRESETn) rst_idx_q <= 3'd0;
    else          rst_idx_q <= rst_idx_d;
  end
`endif

  // FIFO storage write; contents need no reset because the outputs are gated by empty
  always_ff @(posedge HCLK) begin
    if (push_ok && !INIT) fifo_mem[wr_ptr_q[FIFO_AW-1:0]] <= push_entry;
  end

  assign head       = fifo_mem[rd_ptr_q[FIFO_AW-1:0]];
  assign PI_EMPTY   = fifo_empty;
  assign PI         = fifo_empty ? '0 : head[PI_W-1:0];
  assign PI_RST_MRK = ~fifo_empty & head[PI_W];
  assign PI_EOI_MRK = ~fifo_empty & head[PI_W+1];
  assign BS_AFULL   = afull_q;
  assign ERR_INFO   = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_jpeg_dec_bs_preproc.sv
// tb_jpeg_dec_bs_preproc
//   Directed and randomized stimulus for jpeg_dec_bs_preproc. A queue-based
//   reference model builds the expected words, tags, error flags and FIFO
//   occupancy.
module tb_jpeg_dec_bs_preproc;

  localparam int PI_W       = 32;
  localparam int FIFO_DEPTH = 8;
  localparam int FIFO_AW    = 3;
  localparam int AFULL_TH   = 2;
  localparam int NB         = PI_W / 8;

  // clock / reset
  logic            HCLK = 1'b0;
  logic            HRESETn = 1'b0;
  logic            INIT = 1'b0;
  logic            BS_EN = 1'b0;
  logic [7:0]      BS_DAT = 8'h00;
  logic            PI_REQ = 1'b0;
  logic            BS_AFULL;
  logic            PI_EMPTY;
  logic [PI_W-1:0] PI;
  logic            PI_RST_MRK;
  logic            PI_EOI_MRK;
  logic [2:0]      ERR_INFO;
  logic [1:0]      dbg_state;

  always #5 HCLK = ~HCLK;

  jpeg_dec_bs_preproc #(
    .PI_W(PI_W), .FIFO_DEPTH(FIFO_DEPTH), .FIFO_AW(FIFO_AW), .AFULL_TH(AFULL_TH)
  ) dut (
    .HCLK(HCLK), .HRESETn(HRESETn), .INIT(INIT), .BS_EN(BS_EN), .BS_DAT(BS_DAT),
    .BS_AFULL(BS_AFULL), .PI_EMPTY(PI_EMPTY), .PI_REQ(PI_REQ), .PI(PI),
    .PI_RST_MRK(PI_RST_MRK), .PI_EOI_MRK(PI_EOI_MRK), .ERR_INFO(ERR_INFO),
    .dbg_state(dbg_state)
  );

  int n_cmp = 0;
  int n_err = 0;

  // scoreboard / reference model: entry = {eoi, rst, word}
  logic [PI_W+1:0] exp_q[$];
  logic [7:0]      m_part[$];
  int              m_state;     // 0 data, 1 after FF, 2 done
  logic [2:0]      m_err;
  int              m_rst_idx;

  task automatic model_clear();
    exp_q.delete();
    m_part.delete();
    m_state   = 0;
    m_err     = 3'b000;
    m_rst_idx = 0;
  endtask

  task automatic model_push(input logic [PI_W+1:0] e);
    if (exp_q.size() >= FIFO_DEPTH) m_err[1] = 1'b1;
    else exp_q.push_back(e);
  endtask

  task automatic model_emit(input logic [1:0] tag);
    logic [PI_W-1:0] w;
    w = '0;
    while (m_part.size() < NB) m_part.push_back(8'hFF);
    for (int i = 0; i < NB; i++) w = {w[PI_W-9:0], m_part[i]};
    m_part.delete();
    model_push({tag, w});
  endtask

  task automatic model_append(input logic [7:0] b);
    m_part.push_back(b);
    if (m_part.size() == NB) model_emit(2'b00);
  endtask

  task automatic model_byte(input logic [7:0] b);
    case (m_state)
      0: if (b == 8'hFF) m_state = 1; else model_append(b);
      1: begin
        if (b == 8'h00) begin
          model_append(8'hFF);
          m_state = 0;
        end else if (b == 8'hFF) begin
          m_state = 1;
        end else if (b >= 8'hD0 && b <= 8'hD7) begin
`ifdef JPEG_DEC_RST_SEQ_CHK_EN
          if ((int'(b) - 'hD0) != m_rst_idx) m_err[2] = 1'b1;
          m_rst_idx = (int'(b) - 'hD0 + 1) % 8;
`endif
          model_emit(2'b01);
          m_state = 0;
        end else if (b == 8'hD9) begin
          model_emit(2'b10);
          m_state = 2;
        end else begin
          m_err[0] = 1'b1;
          m_state  = 0;
        end
      end
      default: ;
    endcase
  endtask

  // driver: one clock cycle with optional byte and pop request, fully checked
  task automatic cycle(input logic en, input logic [7:0] d, input logic req);
    logic exp_empty;
    exp_empty = (exp_q.size() == 0);
    n_cmp++;
    if (PI_EMPTY !== exp_empty) begin
      n_err++;
      $display("FAIL empty: got %b exp %b at %0t", PI_EMPTY, exp_empty, $time);
    end
    if (exp_empty) begin
      n_cmp++;
      if ({PI_EOI_MRK, PI_RST_MRK} !== 2'b00) begin
        n_err++;
        $display("FAIL tags_when_empty: got %b exp 00", {PI_EOI_MRK, PI_RST_MRK});
      end
    end
    if (req && !exp_empty) begin
      n_cmp++;
      if ({PI_EOI_MRK, PI_RST_MRK, PI} !== exp_q[0]) begin
        n_err++;
        $display("FAIL head: got %h exp %h at %0t",
                 {PI_EOI_MRK, PI_RST_MRK, PI}, exp_q[0], $time);
      end
      void'(exp_q.pop_front());
    end
    BS_EN = en; BS_DAT = d; PI_REQ = req;
    @(posedge HCLK); #1;
    BS_EN = 1'b0; PI_REQ = 1'b0;
    if (en) model_byte(d);
    n_cmp++;
    if (ERR_INFO !== m_err) begin
      n_err++;
      $display("FAIL err_info: got %b exp %b at %0t", ERR_INFO, m_err, $time);
    end
    n_cmp++;
    if (BS_AFULL !== ((FIFO_DEPTH - exp_q.size()) <= AFULL_TH)) begin
      n_err++;
      $display("FAIL afull: got %b exp %b at %0t", BS_AFULL,
               ((FIFO_DEPTH - exp_q.size()) <= AFULL_TH), $time);
    end
  endtask

  task automatic check_reset_vals(input string nm);
    n_cmp++;
    if (PI_EMPTY !== 1'b1 || PI !== '0 || PI_RST_MRK !== 1'b0 || PI_EOI_MRK !== 1'b0 ||
        BS_AFULL !== 1'b0 || ERR_INFO !== 3'b000) begin
      n_err++;
      $display("FAIL %s: got empty=%b pi=%h rst=%b eoi=%b afull=%b err=%b exp 1/0/0/0/0/000",
               nm, PI_EMPTY, PI, PI_RST_MRK, PI_EOI_MRK, BS_AFULL, ERR_INFO);
    end
  endtask

  task automatic do_init(input logic en, input logic [7:0] d, input logic req);
    INIT = 1'b1; BS_EN = en; BS_DAT = d; PI_REQ = req;
    @(posedge HCLK); #1;
    INIT = 1'b0; BS_EN = 1'b0; PI_REQ = 1'b0;
    model_clear();
    check_reset_vals("init_values");
  endtask

  task automatic drain();
    for (int k = 0; k < 64 && exp_q.size() != 0; k++) cycle(1'b0, 8'h00, 1'b1);
    n_cmp++;
    if (PI_EMPTY !== 1'b1) begin
      n_err++;
      $display("FAIL drain: got empty=%b exp 1", PI_EMPTY);
    end
  endtask

  task automatic send_bytes(input logic [7:0] b[$]);
    foreach (b[i]) cycle(1'b1, b[i], 1'b0);
  endtask

  task automatic test_reset();
    check_reset_vals("reset_values");
  endtask

  task automatic test_stuffing();
    do_init(1'b0, 8'h00, 1'b0);
    send_bytes('{8'h12, 8'hFF, 8'h00, 8'h34});
    n_cmp++;
    if (PI_EMPTY !== 1'b1) begin n_err++; $display("FAIL t1_early: got empty=%b exp 1", PI_EMPTY); end
    cycle(1'b1, 8'h56, 1'b0);
    n_cmp++;
    if (PI_EMPTY !== 1'b0 || PI !== 32'h12FF3456 || PI_RST_MRK !== 1'b0 || PI_EOI_MRK !== 1'b0) begin
      n_err++;
      $display("FAIL t1_word: got empty=%b pi=%h rst=%b eoi=%b exp 0 12ff3456 0 0",
               PI_EMPTY, PI, PI_RST_MRK, PI_EOI_MRK);
    end
    drain();
  endtask

  task automatic test_rst_flush();
    do_init(1'b0, 8'h00, 1'b0);
    send_bytes('{8'hAB, 8'hCD, 8'hFF, 8'hD0});
    n_cmp++;
    if (PI !== 32'hABCDFFFF || PI_RST_MRK !== 1'b1 || PI_EOI_MRK !== 1'b0) begin
      n_err++;
      $display("FAIL t2_partial: got pi=%h rst=%b eoi=%b exp abcdffff 1 0", PI, PI_RST_MRK, PI_EOI_MRK);
    end
    cycle(1'b0, 8'h00, 1'b1);
    send_bytes('{8'hFF, 8'hD1});
    n_cmp++;
    if (PI !== 32'hFFFFFFFF || PI_RST_MRK !== 1'b1) begin
      n_err++;
      $display("FAIL t2_empty_flush: got pi=%h rst=%b exp ffffffff 1", PI, PI_RST_MRK);
    end
    drain();
  endtask

  task automatic test_eoi_done();
    do_init(1'b0, 8'h00, 1'b0);
    send_bytes('{8'h01, 8'hFF, 8'hD9, 8'h22});
    n_cmp++;
    if (PI !== 32'h01FFFFFF || PI_EOI_MRK !== 1'b1 || PI_RST_MRK !== 1'b0) begin
      n_err++;
      $display("FAIL t3_eoi: got pi=%h eoi=%b rst=%b exp 01ffffff 1 0", PI, PI_EOI_MRK, PI_RST_MRK);
    end
    cycle(1'b0, 8'h00, 1'b1);
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h44, 8'hFF, 8'hD0});
    n_cmp++;
    if (PI_EMPTY !== 1'b1) begin n_err++; $display("FAIL t3_done: got empty=%b exp 1", PI_EMPTY); end
  endtask

  task automatic test_backpressure();
    logic [7:0] b;
    do_init(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 40; i++) begin
      b = 8'($urandom_range(0, 254));
      cycle(1'b1, b, 1'b0);
      if (i == 19) begin
        n_cmp++;
        if (BS_AFULL !== 1'b0) begin n_err++; $display("FAIL t4_afull5: got %b exp 0", BS_AFULL); end
      end
      if (i == 23) begin
        n_cmp++;
        if (BS_AFULL !== 1'b1) begin n_err++; $display("FAIL t4_afull6: got %b exp 1", BS_AFULL); end
      end
      if (i == 31) begin
        n_cmp++;
        if (ERR_INFO[1] !== 1'b0) begin n_err++; $display("FAIL t4_ovf8: got %b exp 0", ERR_INFO[1]); end
      end
      if (i == 35) begin
        n_cmp++;
        if (ERR_INFO[1] !== 1'b1) begin n_err++; $display("FAIL t4_ovf9: got %b exp 1", ERR_INFO[1]); end
      end
    end
    drain();
    // full FIFO with a push and a pop on the same edge
    do_init(1'b0, 8'h00, 1'b0);
    for (int i = 0; i < 35; i++) cycle(1'b1, 8'($urandom_range(0, 254)), 1'b0);
    cycle(1'b1, 8'($urandom_range(0, 254)), 1'b1);
    n_cmp++;
    if (ERR_INFO[1] !== 1'b0 || BS_AFULL !== 1'b1 || PI_EMPTY !== 1'b0) begin
      n_err++;
      $display("FAIL t4_push_pop_full: got ovf=%b afull=%b empty=%b exp 0 1 0",
               ERR_INFO[1], BS_AFULL, PI_EMPTY);
    end
    drain();
  endtask

  task automatic test_errors_init();
    do_init(1'b0, 8'h00, 1'b0);
    send_bytes('{8'hFF, 8'hC4});
    n_cmp++;
    if (ERR_INFO[0] !== 1'b1) begin n_err++; $display("FAIL t5_unknown: got %b exp 1", ERR_INFO[0]); end
    do_init(1'b0, 8'h00, 1'b0);
    send_bytes('{8'hFF, 8'hD0, 8'hFF, 8'hD2});
    n_cmp++;
`ifdef JPEG_DEC_RST_SEQ_CHK_EN
    if (ERR_INFO[2] !== 1'b1) begin n_err++; $display("FAIL t5_seq: got %b exp 1", ERR_INFO[2]); end
`else
    if (ERR_INFO[2] !== 1'b0) begin n_err++; $display("FAIL t5_seq: got %b exp 0", ERR_INFO[2]); end
`endif
    send_bytes('{8'h9A, 8'hBC});
    do_init(1'b1, 8'h55, 1'b1);
    send_bytes('{8'h11, 8'h22, 8'h33, 8'h44});
    n_cmp++;
    if (PI !== 32'h11223344 || PI_EMPTY !== 1'b0) begin
      n_err++;
      $display("FAIL t5_init_byte_lost: got pi=%h empty=%b exp 11223344 0", PI, PI_EMPTY);
    end
    drain();
  endtask

  task automatic test_async_reset();
    do_init(1'b0, 8'h00, 1'b0);
    send_bytes('{8'hFF, 8'hC4});
    for (int i = 0; i < 18; i++) cycle(1'b1, 8'($urandom_range(0, 254)), 1'b0);
    #2 HRESETn = 1'b0;
    #1;
    check_reset_vals("t6_async");
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    model_clear();
    send_bytes('{8'hDE, 8'hAD, 8'hFF, 8'h00, 8'hEF, 8'h01, 8'hFF, 8'hD0});
    n_cmp++;
    if (PI !== 32'hDEADFFEF || PI_RST_MRK !== 1'b0) begin
      n_err++;
      $display("FAIL t6_fresh: got pi=%h rst=%b exp deadffef 0", PI, PI_RST_MRK);
    end
    drain();
  endtask

  task automatic test_random();
    logic       prev_ff;
    logic       en;
    logic       req;
    logic [7:0] b;
    int         r;
    do_init(1'b0, 8'h00, 1'b0);
    prev_ff = 1'b0;
    for (int i = 0; i < 1500; i++) begin
      req = ($urandom_range(0, 2) != 0);
      en  = !BS_AFULL && ($urandom_range(0, 3) != 0);
      b   = 8'h00;
      if (en) begin
        if (prev_ff) begin
          r = $urandom_range(0, 15);
          if (r <= 5 || r == 15) b = 8'h00;
          else if (r == 6)       b = 8'hFF;
          else if (r <= 13)      b = 8'hD0 + 8'($urandom_range(0, 7));
          else                   b = 8'hC4;
        end else begin
          b = ($urandom_range(0, 7) == 0) ? 8'hFF : 8'($urandom_range(0, 254));
        end
        prev_ff = (b == 8'hFF);
      end
      cycle(en, b, req);
    end
    drain();
    send_bytes('{8'h5A, 8'hFF, 8'hD9, 8'h77});
    drain();
  endtask

  initial begin
    repeat (3) @(posedge HCLK);
    @(negedge HCLK); HRESETn = 1'b1;
    @(posedge HCLK); #1;
    model_clear();
    test_reset();
    test_stuffing();
    test_rst_flush();
    test_eoi_done();
    test_backpressure();
    test_errors_init();
    test_async_reset();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
